// File: rtl/system.sv
// UART echo system: receives 8N1 bytes on uart_rxd, queues them in a 4-entry
// FIFO and retransmits them on uart_txd. led toggles once per valid byte.
// Optional feature: define SYSTEM_UPCASE_EN to echo 'a'..'z' as 'A'..'Z'.
`timescale 1ns/1ps
module system #(
    parameter int unsigned clk_freq       = 100000000,
    parameter int unsigned uart_baud_rate = 115200
) (
    input  logic clk,
    input  logic rst,
    output logic led,
    input  logic uart_rxd,
    output logic uart_txd
);
    localparam int unsigned Div  = clk_freq / uart_baud_rate;
    localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] DivLast  = CntW'(Div - 1);
    localparam logic [CntW-1:0] DivPre   = CntW'(Div - 2);
    localparam logic [CntW-1:0] HalfLast = CntW'(Div / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    // ------------------------------------------------------------------
    // RX synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic rxd_fall;

    // Sync flops reset low so a line held low across reset release never
    // looks like a start edge; the line must be seen high first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b0;
            rxd_sync_q <= 1'b0;
            rxd_prev_q <= 1'b0;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign rxd_fall = rxd_prev_q & ~rxd_sync_q;

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_done;
    logic            rx_valid_q;
    logic            led_q;

    // RX next-state: half-bit to start midpoint, then whole bits thereafter
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CntW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rxd_fall) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    // High at the midpoint means the edge was a glitch
                    rx_state_d = rxd_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == DivLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == DivLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    // A low stop bit is a framing error; byte is discarded and
                    // the edge detector needs the line high again.
                    rx_done    = rxd_sync_q;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX state registers, byte-valid strobe and activity LED
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_valid_q <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_done;
            if (rx_done) led_q <= ~led_q;
        end
    end

    // ------------------------------------------------------------------
    // Echo byte transform
    // ------------------------------------------------------------------
    logic [7:0] echo_byte;

`ifdef SYSTEM_UPCASE_EN
    // Lower-case ASCII letters are converted to upper case
    always_comb begin
        echo_byte = rx_shift_q;
        if (rx_shift_q >= 8'h61 && rx_shift_q <= 8'h7A) echo_byte = rx_shift_q - 8'h20;
    end
`else
    assign echo_byte = rx_shift_q;
`endif

    // ------------------------------------------------------------------
    // 4-entry echo FIFO
    // ------------------------------------------------------------------
    logic [7:0] fifo_mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       fifo_push, fifo_pop, fifo_empty, fifo_full;

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    // rx_shift_q is stable for half a bit after the stop sample, so it is
    // still the received byte on the cycle after rx_done.
    assign fifo_push  = rx_valid_q & ~fifo_full;

    // FIFO storage and pointers; push and pop may occur together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) fifo_mem_q[i] <= 8'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (fifo_push) begin
                fifo_mem_q[wr_ptr_q] <= echo_byte;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + 3'(fifo_push) - 3'(fifo_pop);
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            txd_q, txd_d;

    // TX next-state; STOP leaves one cycle early so the IDLE pop cycle
    // completes the stop bit and frames run back to back.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CntW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        fifo_pop   = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_mem_q[rd_ptr_q];
                    txd_d      = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == DivLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tx_cnt_q == DivLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            TxStop: begin
                if (tx_cnt_q == DivPre) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // TX state registers; line forced high asynchronously on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign uart_txd = txd_q;
    assign led      = led_q;

endmodule

// File: tb/tb_system.sv
// Directed testbench for the UART echo system at 100 MHz / 1152000 baud.
`timescale 1ns/1ps
module tb_system;
    localparam int unsigned ClkFreq = 100000000;
    localparam int unsigned Baud    = 1152000;
    localparam int DIV = 86;
    // Negedges from driving the start bit to seeing uart_txd low:
    // 2 sync flops + 1 edge-detect cycle, DIV/2 to start midpoint, 9*DIV to the
    // stop sample, 2 cycles to uart_txd, then the following negedge.
    localparam int ECHO_NEG = 3 + DIV / 2 + 9 * DIV + 2 + 1;

`ifdef SYSTEM_UPCASE_EN
    localparam logic [7:0] EXP_LOWER_A = 8'h41;
`else
    localparam logic [7:0] EXP_LOWER_A = 8'h61;
`endif

    logic clk;
    logic rst;
    logic led;
    logic uart_rxd;
    logic uart_txd;

    system #(
        .clk_freq      (ClkFreq),
        .uart_baud_rate(Baud)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led     (led),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // TX line decoder, sampling each bit at its midpoint on the falling clock
    int unsigned ncyc = 0;
    logic [7:0]  rx_q[$];
    int unsigned start_q[$];
    int          mon_err     = 0;
    int          led_toggles = 0;
    logic        led_prev    = 1'b0;
    logic        mon_busy    = 1'b0;
    int          mon_cnt     = 0;
    logic [7:0]  mon_byte    = 8'd0;

    always @(negedge clk) begin
        int k;
        ncyc++;
        if (led !== led_prev) led_toggles++;
        led_prev = led;
        if (!rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (uart_txd === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                start_q.push_back(ncyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % DIV == DIV / 2) begin
                k = mon_cnt / DIV;
                if (k == 0) begin
                    if (uart_txd !== 1'b0) mon_err++;
                end else if (k <= 8) begin
                    mon_byte[k-1] = uart_txd;
                end else begin
                    if (uart_txd !== 1'b1) mon_err++;
                    rx_q.push_back(mon_byte);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            wait_cyc(DIV);
        end
    endtask

    task automatic wait_echo(input int n, input string tag);
        int cnt;
        cnt = 0;
        while (rx_q.size() < n && cnt < 4000) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        check({tag, "_count"}, rx_q.size(), n);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        start_q.delete();
    endtask

    int unsigned t0;
    int          tog0;

    initial begin
        uart_rxd = 1'b1;
        rst      = 1'b0;

        // Reset behaviour
        #20;
        check("reset_txd_a", uart_txd, 1);
        check("reset_led_a", led, 0);
        #40;
        check("reset_txd_b", uart_txd, 1);
        check("reset_led_b", led, 0);
        #20;
        rst = 1'b1;
        wait_cyc(10000);
        check("idle_no_tx", start_q.size(), 0);
        check("idle_txd", uart_txd, 1);
        check("idle_led_toggles", led_toggles, 0);

        // Single echo with latency
        clear_mon();
        t0 = ncyc;
        send_byte(8'h55, 1'b1);
        wait_echo(1, "echo");
        if (rx_q.size() >= 1) check("echo_data", rx_q[0], 8'h55);
        if (start_q.size() >= 1) check("echo_latency", start_q[0] - t0, ECHO_NEG);
        check("echo_led", led, 1);
        check("echo_led_toggles", led_toggles, 1);

        // Case conversion
        clear_mon();
        send_byte(8'h61, 1'b1);
        wait_echo(1, "case_a");
        if (rx_q.size() >= 1) check("case_a_data", rx_q[0], EXP_LOWER_A);
        check("case_a_led", led, 0);
        clear_mon();
        send_byte(8'h5A, 1'b1);
        wait_echo(1, "case_z");
        if (rx_q.size() >= 1) check("case_z_data", rx_q[0], 8'h5A);
        check("case_z_led", led, 1);

        // Back-to-back burst
        clear_mon();
        tog0 = led_toggles;
        for (int b = 1; b <= 6; b++) send_byte(8'(b), 1'b1);
        wait_echo(6, "burst");
        for (int i = 0; i < 6; i++)
            if (rx_q.size() > i) check($sformatf("burst_data%0d", i), rx_q[i], i + 1);
        for (int i = 1; i < 6; i++)
            if (start_q.size() > i)
                check($sformatf("burst_gap%0d", i), start_q[i] - start_q[i-1], 10 * DIV);
        check("burst_led_toggles", led_toggles - tog0, 6);

        // Framing error then glitch
        clear_mon();
        tog0 = led_toggles;
        send_byte(8'hA5, 1'b0);
        uart_rxd = 1'b1;
        wait_cyc(2000);
        check("ferr_no_echo", start_q.size(), 0);
        check("ferr_led_toggles", led_toggles - tog0, 0);
        uart_rxd = 1'b0;
        wait_cyc(20);
        uart_rxd = 1'b1;
        wait_cyc(2000);
        check("glitch_no_echo", start_q.size(), 0);
        check("glitch_led_toggles", led_toggles - tog0, 0);
        send_byte(8'h33, 1'b1);
        wait_echo(1, "recover");
        if (rx_q.size() >= 1) check("recover_data", rx_q[0], 8'h33);

        // Reset during TX data bit 3 (0xF0 has bit 3 low)
        clear_mon();
        send_byte(8'hF0, 1'b1);
        begin
            int cnt;
            cnt = 0;
            while (start_q.size() == 0 && cnt < 2000) begin
                @(negedge clk);
                cnt++;
            end
            check("mid_tx_started", start_q.size(), 1);
            cnt = 0;
            while (start_q.size() > 0 && (ncyc - start_q[0]) < 4 * DIV + DIV / 2 && cnt < 2000) begin
                @(negedge clk);
                cnt++;
            end
        end
        check("mid_bit3_low", uart_txd, 0);
        rst      = 1'b0;
        uart_rxd = 1'b0;
        #1;
        check("mid_async_txd", uart_txd, 1);
        check("mid_led", led, 0);
        clear_mon();
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(200);
        uart_rxd = 1'b1;
        wait_cyc(2000);
        check("low_release_no_echo", start_q.size(), 0);
        check("low_release_led", led, 0);
        send_byte(8'h3C, 1'b1);
        wait_echo(1, "post_reset");
        if (rx_q.size() >= 1) check("post_reset_data", rx_q[0], 8'h3C);
        check("post_reset_led", led, 1);

        check("monitor_frame_errors", mon_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/system.md
SYSTEM -- requirements
Module: system

Interface
REQ-001 The module SHALL have parameter clk_freq, default 100000000, meaning clock frequency in Hz.
REQ-002 The module SHALL have parameter uart_baud_rate, default 115200, meaning UART bit rate in baud.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset asserted).
REQ-005 Port led, output, 1 bit: activity indicator.
REQ-006 Port uart_rxd, input, 1 bit: UART serial receive line, idle high.
REQ-007 Port uart_txd, output, 1 bit: UART serial transmit line, idle high.

Function
REQ-008 Bit period DIV SHALL be clk_freq/uart_baud_rate with integer truncation (100 MHz at 1152000 baud gives DIV=86).
REQ-009 Frame format SHALL be 8N1, LSB first, for both directions.
REQ-010 uart_rxd SHALL pass through a 2-flop synchronizer before use; all RX timing refers to the synchronized signal.
REQ-011 RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE->START SHALL occur on a synchronized 1->0 transition.
REQ-013 In START the line SHALL be resampled DIV/2 cycles after the edge: if 0, go to DATA; if 1, treat as a glitch and return to IDLE.
REQ-014 In DATA, 8 bits SHALL be sampled at DIV-cycle intervals from the start-bit midpoint.
REQ-015 In STOP the line SHALL be sampled DIV cycles after bit 7.
REQ-016 A stop sample of 1 SHALL make the byte valid.
REQ-017 A stop sample of 0 SHALL be a framing error: discard the byte, then wait in IDLE until the line is seen high before accepting a new falling edge.
REQ-018 Each valid byte SHALL be written into a 4-entry echo FIFO the cycle after the stop sample.
REQ-019 If the FIFO is full, the new byte SHALL be dropped and FIFO contents left unchanged.
REQ-020 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-021 When TX is IDLE and the FIFO is non-empty, TX SHALL pop the oldest byte and drive uart_txd low the following cycle.
REQ-022 Each TX bit (start, 8 data, stop) SHALL be held exactly DIV cycles.
REQ-023 After the stop bit, TX SHALL return to IDLE and may start the next byte on the very next cycle, giving back-to-back frames with no extra idle time.
REQ-024 Echo latency: with TX idle and FIFO empty, uart_txd SHALL fall exactly 2 clk cycles after the RX stop-sample cycle.
REQ-025 A simultaneous FIFO push and pop SHALL be legal, and the FIFO occupancy SHALL remain unchanged.
REQ-026 led SHALL toggle once per valid received byte, including bytes dropped on FIFO full.
REQ-027 led SHALL NOT toggle on framing errors or glitches.

Reset
REQ-028 While rst=0, uart_txd SHALL be 1 and led SHALL be 0.
REQ-029 While rst=0, both FSMs SHALL be in IDLE, the FIFO SHALL be empty and all counters SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort RX and TX immediately; uart_txd SHALL return high asynchronously.
REQ-031 After release, RX SHALL first require the synchronized line high before edge detection, so a low line at release SHALL NOT produce a frame.

Configuration
REQ-032 Macro SYSTEM_UPCASE_EN SHALL control case conversion of echoed bytes.
REQ-033 When SYSTEM_UPCASE_EN is defined, bytes 0x61-0x7A ('a'-'z') SHALL be echoed minus 0x20; all other bytes SHALL be echoed unchanged.
REQ-034 When SYSTEM_UPCASE_EN is not defined, every byte SHALL be echoed unchanged.

Verification
REQ-035 Reset: rst=0 for 80 ns, then 1 -> uart_txd=1 and led=0 throughout, and no TX activity for 10000 cycles with uart_rxd=1.
REQ-036 Echo: send 0x55 at DIV=86 (100 MHz, 1152000 baud) -> uart_txd falls 2 cycles after the stop sample, frame reads 0x55 with 86-cycle bits, and led goes 0->1.
REQ-037 Case: send 0x61 -> echo 0x41 with the macro defined, 0x61 without it; send 0x5A -> echo 0x5A in both builds.
REQ-038 Burst: 6 back-to-back bytes 0x01..0x06 -> echoes appear in order with no gaps, all bytes received, and led toggles 6 times.
REQ-039 Errors: frame with stop bit 0 -> no echo, led unchanged; 20-cycle low glitch -> no echo, led unchanged.
REQ-040 Mid-frame reset: assert rst during TX bit 3 -> uart_txd goes to 1 immediately, and a new byte after release echoes correctly.
